// File: rtl/isa_io_pkg.sv
// Shared definitions for the ISA I/O window decoder.
//   state_e      : decoder FSM state encoding (2-bit)
//   *_BASE/_MASK : legacy PC/AT default map (FDC, primary/secondary WD),
//                  handy as power-on programming values for the window table
package isa_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_e;

  localparam logic [15:0] FDC_BASE        = 16'h03F0;
  localparam logic [15:0] FDC_MASK        = 16'h0007;
  localparam logic [15:0] WD_PRI_BASE     = 16'h01F0;
  localparam logic [15:0] WD_PRI_MASK     = 16'h0007;
  localparam logic [15:0] WD_PRI_ALT_BASE = 16'h03F6;
  localparam logic [15:0] WD_PRI_ALT_MASK = 16'h0001;
  localparam logic [15:0] WD_SEC_BASE     = 16'h0170;
  localparam logic [15:0] WD_SEC_MASK     = 16'h0007;
  localparam logic [15:0] WD_SEC_ALT_BASE = 16'h0376;
  localparam logic [15:0] WD_SEC_ALT_MASK = 16'h0001;

endpackage

// File: rtl/isa_strobe_sync.sv
// Two-flop synchroniser for one asynchronous active-low ISA strobe, plus a
// registered assertion-edge pulse.
//   clk, reset_n : system clock, async active-low reset
//   strb_n       : raw strobe pin (async, active low)
//   sync_n       : synchronised strobe level (1 = deasserted)
//   fell         : one-cycle pulse, registered one edge after the synced
//                  level first shows the assertion
module isa_strobe_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic strb_n,
  output logic sync_n,
  output logic fell
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic dly_q, dly_d;
  logic fell_q, fell_d;

  always_comb begin
    s1_d   = strb_n;
    s2_d   = s1_q;
    dly_d  = s2_q;
    fell_d = ~s2_q & dly_q;
  end

  // Chain presets to the deasserted level so reset never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      dly_q  <= 1'b1;
      fell_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      dly_q  <= dly_d;
      fell_q <= fell_d;
    end
  end

  assign sync_n = s2_q;
  assign fell   = fell_q;

endmodule

// File: rtl/isa_io_window_decode.sv
// ISA I/O decoder with NUM_WIN runtime-programmable windows.
// Synchronises IOR#/IOW#, matches the sampled address against the window
// table (lowest index wins), inserts IOCHRDY wait states and issues a
// single-cycle rd_stb/wr_stb to the device register blocks.
//   isa_*        : ISA pin side (address, AEN, async strobes)
//   cfg_*        : window table write port (one entry per cfg_we cycle)
//   err_clr      : clears the sticky conflict/proto_err flags
//   iochrdy_oe   : 1 = pull IOCHRDY low (insert wait)
//   rd_stb/wr_stb: one-cycle device strobes
//   cyc_win/cyc_offset : latched window index and register offset
//   busy         : FSM not idle
module isa_io_window_decode
  import isa_io_pkg::*;
#(
  parameter  int NUM_WIN = 4,
  parameter  int ADDR_W  = 10,
  parameter  int WS_W    = 4,
  localparam int WIN_W   = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] isa_addr,
  input  logic              isa_aen,
  input  logic              isa_ior_n,
  input  logic              isa_iow_n,
  input  logic              cfg_we,
  input  logic [WIN_W-1:0]  cfg_win,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [ADDR_W-1:0] cfg_mask,
  input  logic [WS_W-1:0]   cfg_wait,
  input  logic              cfg_en,
  input  logic              err_clr,
  output logic              iochrdy_oe,
  output logic              rd_stb,
  output logic              wr_stb,
  output logic [WIN_W-1:0]  cyc_win,
  output logic [ADDR_W-1:0] cyc_offset,
  output logic              busy,
  output logic              conflict,
  output logic              proto_err
);

  // ---------------------------------------------------------------- sync
  logic rd_sync_n, rd_fell, wr_sync_n, wr_fell;

  isa_strobe_sync u_ior_sync (
    .clk(clk), .reset_n(reset_n), .strb_n(isa_ior_n),
    .sync_n(rd_sync_n), .fell(rd_fell)
  );

  isa_strobe_sync u_iow_sync (
    .clk(clk), .reset_n(reset_n), .strb_n(isa_iow_n),
    .sync_n(wr_sync_n), .fell(wr_fell)
  );

  // Address/AEN sampled every edge; the copy taken alongside the edge pulse
  // is the one the FSM decodes.
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              aen_q, aen_d;

  // --------------------------------------------------------- window table
  logic [NUM_WIN-1:0][ADDR_W-1:0] base_q, base_d;
  logic [NUM_WIN-1:0][ADDR_W-1:0] mask_q, mask_d;
  logic [NUM_WIN-1:0][WS_W-1:0]   wait_q, wait_d;
  logic [NUM_WIN-1:0]             en_q, en_d;

  // Per-index compare silently drops out-of-range cfg_win values.
  always_comb begin
    base_d = base_q;
    mask_d = mask_q;
    wait_d = wait_q;
    en_d   = en_q;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (cfg_we && (cfg_win == WIN_W'(w))) begin
        base_d[w] = cfg_base;
        mask_d[w] = cfg_mask;
        wait_d[w] = cfg_wait;
        en_d[w]   = cfg_en;
      end
    end
  end

  // ------------------------------------------------------------ hit logic
  logic             hit_any, hit_multi;
  logic [WIN_W-1:0] hit_idx;

  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    hit_idx   = '0;
    for (int w = 0; w < NUM_WIN; w++) begin
      if (en_q[w] && (((addr_q ^ base_q[w]) & ~mask_q[w]) == '0)) begin
        if (hit_any) hit_multi = 1'b1;
        else         hit_idx   = WIN_W'(w);
        hit_any = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ FSM
  state_e            state_q, state_d;
  logic [WS_W-1:0]   cnt_q, cnt_d;
  logic              dir_wr_q, dir_wr_d;
  logic [WIN_W-1:0]  cyc_win_q, cyc_win_d;
  logic [ADDR_W-1:0] cyc_off_q, cyc_off_d;
  logic              conflict_q, conflict_d;
  logic              proto_q, proto_d;
  logic              proto_evt;

  // Overlapping strobes: both edges together, or one edge while the other
  // strobe is already low.
  assign proto_evt = (rd_fell && (wr_fell || !wr_sync_n)) ||
                     (wr_fell && !rd_sync_n);

  always_comb begin
    addr_d     = isa_addr;
    aen_d      = isa_aen;
    state_d    = state_q;
    cnt_d      = cnt_q;
    dir_wr_d   = dir_wr_q;
    cyc_win_d  = cyc_win_q;
    cyc_off_d  = cyc_off_q;
    // Clear first so a same-cycle set event below overrides it.
    conflict_d = conflict_q & ~err_clr;
    proto_d    = proto_q & ~err_clr;

    unique case (state_q)
      ST_IDLE: begin
        if (rd_fell || wr_fell) begin
          if (proto_evt) begin
            proto_d = 1'b1;
            state_d = ST_HOLD;
          end else if (aen_q || !hit_any) begin
            state_d = ST_HOLD;
          end else begin
            cyc_win_d = hit_idx;
            cyc_off_d = addr_q & mask_q[hit_idx];
            dir_wr_d  = wr_fell;
            cnt_d     = wait_q[hit_idx];
            if (hit_multi) conflict_d = 1'b1;
            state_d = (wait_q[hit_idx] != '0) ? ST_WAIT : ST_STROBE;
          end
        end
      end
      ST_WAIT: begin
        // cnt_q == 1 means this is the last wait cycle.
        if (aen_q)                   state_d = ST_HOLD;
        else if (cnt_q <= WS_W'(1))  state_d = ST_STROBE;
        else                         cnt_d   = cnt_q - WS_W'(1);
      end
      ST_STROBE: state_d = ST_HOLD;
      ST_HOLD: begin
        if (rd_sync_n && wr_sync_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      base_q     <= '0;
      mask_q     <= '0;
      wait_q     <= '0;
      en_q       <= '0;
      addr_q     <= '0;
      aen_q      <= 1'b0;
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dir_wr_q   <= 1'b0;
      cyc_win_q  <= '0;
      cyc_off_q  <= '0;
      conflict_q <= 1'b0;
      proto_q    <= 1'b0;
    end else begin
      base_q     <= base_d;
      mask_q     <= mask_d;
      wait_q     <= wait_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      aen_q      <= aen_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dir_wr_q   <= dir_wr_d;
      cyc_win_q  <= cyc_win_d;
      cyc_off_q  <= cyc_off_d;
      conflict_q <= conflict_d;
      proto_q    <= proto_d;
    end
  end

  // Outputs decode straight from state flops, so async reset drops
  // iochrdy_oe immediately.
  assign iochrdy_oe = (state_q == ST_WAIT);
  assign rd_stb     = (state_q == ST_STROBE) && !dir_wr_q;
  assign wr_stb     = (state_q == ST_STROBE) &&  dir_wr_q;
  assign busy       = (state_q != ST_IDLE);
  assign cyc_win    = cyc_win_q;
  assign cyc_offset = cyc_off_q;
  assign conflict   = conflict_q;
  assign proto_err  = proto_q;

endmodule

// File: tb/tb_isa_io_window_decode.sv
module tb_isa_io_window_decode;
  import isa_io_pkg::*;

  localparam int NUM_WIN = 4;
  localparam int ADDR_W  = 10;
  localparam int WS_W    = 4;
  localparam int WIN_W   = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [ADDR_W-1:0] isa_addr = '0;
  logic              isa_aen = 1'b0;
  logic              isa_ior_n = 1'b1;
  logic              isa_iow_n = 1'b1;
  logic              cfg_we = 1'b0;
  logic [WIN_W-1:0]  cfg_win = '0;
  logic [ADDR_W-1:0] cfg_base = '0;
  logic [ADDR_W-1:0] cfg_mask = '0;
  logic [WS_W-1:0]   cfg_wait = '0;
  logic              cfg_en = 1'b0;
  logic              err_clr = 1'b0;
  logic              iochrdy_oe, rd_stb, wr_stb, busy, conflict, proto_err;
  logic [WIN_W-1:0]  cyc_win;
  logic [ADDR_W-1:0] cyc_offset;

  isa_io_window_decode #(.NUM_WIN(NUM_WIN), .ADDR_W(ADDR_W), .WS_W(WS_W)) dut (
    .clk(clk), .reset_n(reset_n), .isa_addr(isa_addr), .isa_aen(isa_aen),
    .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n), .cfg_we(cfg_we),
    .cfg_win(cfg_win), .cfg_base(cfg_base), .cfg_mask(cfg_mask),
    .cfg_wait(cfg_wait), .cfg_en(cfg_en), .err_clr(err_clr),
    .iochrdy_oe(iochrdy_oe), .rd_stb(rd_stb), .wr_stb(wr_stb),
    .cyc_win(cyc_win), .cyc_offset(cyc_offset), .busy(busy),
    .conflict(conflict), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected strobe: direction, window, offset, wait count, drive time.
  typedef struct {
    bit  wr;
    int  win;
    int  off;
    int  ws;
    time t;
  } exp_t;

  exp_t exp_q[$];

  // Monitor: every strobe must match the oldest pending expectation,
  // including the IOCHRDY wait run and latency from strobe drive.
  initial begin
    int   oe_run;
    exp_t e;
    oe_run = 0;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (!busy)           oe_run = 0;
        else if (iochrdy_oe) oe_run++;
        if (rd_stb || wr_stb) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_stb", 32'(rd_stb | wr_stb), 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("stb_dir",    32'(wr_stb), 32'(e.wr));
            chk("stb_both",   32'(rd_stb & wr_stb), 32'd0);
            chk("cyc_win",    32'(cyc_win), 32'(e.win));
            chk("cyc_offset", 32'(cyc_offset), 32'(e.off));
            chk("oe_cycles",  32'(oe_run), 32'(e.ws));
            chk("stb_latency", 32'(($time - e.t) / 10), 32'(4 + e.ws));
          end
        end
      end
    end
  end

  task automatic cfg(input int w, input logic [ADDR_W-1:0] base,
                     input logic [ADDR_W-1:0] mask, input int ws, input bit en);
    @(negedge clk);
    cfg_we = 1'b1; cfg_win = WIN_W'(w); cfg_base = base; cfg_mask = mask;
    cfg_wait = WS_W'(ws); cfg_en = en;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) @(negedge clk);
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic pulse_err_clr();
    @(negedge clk); err_clr = 1'b1;
    @(negedge clk); err_clr = 1'b0;
  endtask

  // One ISA I/O cycle; pushes a scoreboard entry when a strobe is expected.
  task automatic io_cyc(input bit wr, input bit both, input logic [ADDR_W-1:0] addr,
                        input bit aen, input bit expect_stb,
                        input int win, input int off, input int ws);
    exp_t e;
    @(negedge clk);
    isa_addr = addr; isa_aen = aen;
    @(negedge clk);
    if (expect_stb) begin
      e.wr = wr; e.win = win; e.off = off; e.ws = ws; e.t = $time;
      exp_q.push_back(e);
    end
    if (wr || both)  isa_iow_n = 1'b0;
    if (!wr || both) isa_ior_n = 1'b0;
    repeat (ws + 8) @(negedge clk);
    chk("busy_held", 32'(busy), 32'd1);
    chk("oe_released", 32'(iochrdy_oe), 32'd0);
    isa_ior_n = 1'b1; isa_iow_n = 1'b1;
    wait_idle();
    chk("exp_drained", 32'(exp_q.size()), 32'd0);
    isa_aen = 1'b0;
  endtask

  initial begin
    bit dropped;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_oe",       32'(iochrdy_oe), 32'd0);
    chk("rst_rd",       32'(rd_stb), 32'd0);
    chk("rst_wr",       32'(wr_stb), 32'd0);
    chk("rst_busy",     32'(busy), 32'd0);
    chk("rst_conflict", 32'(conflict), 32'd0);
    chk("rst_proto",    32'(proto_err), 32'd0);
    chk("rst_win",      32'(cyc_win), 32'd0);
    chk("rst_off",      32'(cyc_offset), 32'd0);
    reset_n = 1'b1;

    // Zero-wait read through window 0
    cfg(0, 10'(FDC_BASE), 10'(FDC_MASK), 0, 1'b1);
    io_cyc(1'b0, 1'b0, 10'h3F5, 1'b0, 1'b1, 0, 5, 0);

    // Three-wait write through window 1
    cfg(1, 10'(WD_PRI_BASE), 10'(WD_PRI_MASK), 3, 1'b1);
    io_cyc(1'b1, 1'b0, 10'h1F7, 1'b0, 1'b1, 1, 7, 3);

    // Single-wait boundary, window 3
    cfg(3, 10'(WD_SEC_BASE), 10'(WD_SEC_MASK), 1, 1'b1);
    io_cyc(1'b0, 1'b0, 10'h172, 1'b0, 1'b1, 3, 2, 1);
    chk("no_conflict_yet", 32'(conflict), 32'd0);

    // Overlap: windows 0 and 2 both hit, window 0 wins
    cfg(2, 10'(WD_PRI_ALT_BASE), 10'(WD_PRI_ALT_MASK), 0, 1'b1);
    io_cyc(1'b0, 1'b0, 10'h3F6, 1'b0, 1'b1, 0, 6, 0);
    chk("conflict_set", 32'(conflict), 32'd1);
    pulse_err_clr();
    chk("conflict_clr", 32'(conflict), 32'd0);

    // AEN high, then a miss: both ignored
    io_cyc(1'b0, 1'b0, 10'h3F2, 1'b1, 1'b0, 0, 0, 0);
    io_cyc(1'b0, 1'b0, 10'h2F8, 1'b0, 1'b0, 0, 0, 0);

    // AEN rising two cycles into a 5-wait cycle aborts it
    cfg(3, 10'(WD_SEC_ALT_BASE), 10'(WD_SEC_ALT_MASK), 5, 1'b1);
    @(negedge clk); isa_addr = 10'h377; isa_aen = 1'b0;
    @(negedge clk); isa_ior_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_in_wait", 32'(iochrdy_oe), 32'd1);
    isa_aen = 1'b1;
    dropped = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (!iochrdy_oe) dropped = 1'b1;
    end
    chk("abort_oe_drop", 32'(dropped), 32'd1);
    isa_ior_n = 1'b1;
    wait_idle();
    isa_aen = 1'b0;

    // IOR# and IOW# together
    chk("proto_clear", 32'(proto_err), 32'd0);
    io_cyc(1'b0, 1'b1, 10'h3F5, 1'b0, 1'b0, 0, 0, 0);
    chk("proto_set", 32'(proto_err), 32'd1);
    pulse_err_clr();
    chk("proto_clr", 32'(proto_err), 32'd0);

    // Async reset in the middle of WAIT
    @(negedge clk); isa_addr = 10'h1F7;
    @(negedge clk); isa_iow_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_pre_oe", 32'(iochrdy_oe), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_async_oe",   32'(iochrdy_oe), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    @(negedge clk); isa_iow_n = 1'b1;
    @(negedge clk); reset_n = 1'b1;
    // Table was cleared: same access now misses
    io_cyc(1'b1, 1'b0, 10'h1F7, 1'b0, 1'b0, 0, 0, 0);

    // Reprogram and confirm normal operation after reset
    cfg(0, 10'(FDC_BASE), 10'(FDC_MASK), 2, 1'b1);
    io_cyc(1'b0, 1'b0, 10'h3F1, 1'b0, 1'b1, 0, 1, 2);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
